mmio_acc_responder: RTL and testbench
=====================================

Name: mmio_acc_responder

Overview:
Memory-mapped responder on the core's external data-memory port. The barrel datapath drives address, write data and write enable from its MEM stage, and reads back a 64-bit word one cycle later. This block decodes the addr[9:8] != 0 window. It holds an operand FIFO and a sum-accumulate engine that software starts, polls and reads back.

Parameters:
D_WIDTH, 64, data/operand/accumulator width
ADDR_WIDTH, 10, byte-address width of the bus
FIFO_DEPTH, 8, operand FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
mem_addr_in  in  ADDR_WIDTH  byte address from datapath MEM stage
mem_data_in  in  D_WIDTH  write data from datapath
mem_we  in  1  write strobe, single cycle per store
mem_rdata  out  D_WIDTH  read data, registered, valid the cycle after the address
busy  out  1  engine in RUN
done  out  1  engine in DONE (level, for polling/irq)

Behaviour:
- One clock, clk; reset_n asynchronous active-low. All flops clear immediately on assertion. Release is sampled on clk.
- Reset values: mem_rdata=0, busy=0, done=0, state=IDLE, FIFO empty, ACC=0, COUNT=0, ovf=0.
- Decode uses addr[9:2]; addr[1:0] ignored. addr[9:8]=00: writes ignored, reads return 0 (d_mem owns it).
- Register map:
  - 0x100 CTRL (W): bit0 start; bit1 clear (ACC=0, ovf=0, DONE->IDLE); reads 0.
  - 0x104 STATUS (R): [0] busy, [1] done, [2] fifo_full, [3] fifo_empty, [4] ovf sticky, [11:8] fifo count.
  - 0x108 ACC (R): accumulator.
  - 0x10C COUNT (R/W): operands remaining.
  - 0x200 FIFO (W): push mem_data_in. R: zero-extended fifo count.
  - Any other address: reads 0, writes ignored.
- Read latency: mem_rdata <= decode(mem_addr_in) on every clk, 1 cycle. Reads have no side effects. Value reflects state before that cycle's edge.
- FIFO push: mem_we at 0x200.
  - Full with no pop in the same cycle: data dropped, ovf<=1.
  - Full with a simultaneous pop: push accepted.
- States:
  - IDLE: start -> RUN. COUNT keeps its written value.
  - RUN: busy=1. Each cycle with FIFO non-empty and COUNT!=0: pop, ACC<=ACC+operand (mod 2^D_WIDTH, carry discarded), COUNT<=COUNT-1. FIFO empty: stall, no change.
  - RUN -> DONE in the cycle COUNT reaches 0, or the cycle after start if COUNT was 0.
  - DONE: done=1. Start -> RUN again (ACC not cleared). Clear -> IDLE.
- Start while in RUN: ignored.
- Writes to COUNT while in RUN: ignored.
- Clear and start in the same cycle are impossible (one store per cycle). The start/clear write sets both bits: clear wins, state=IDLE.
- Reset mid-RUN: FIFO contents lost, state IDLE.

Optional Feature:
ACC_CYCLE_CNT_EN
- Defined: adds register 0x110 CYCLES (R). It clears on start and clear, and increments every cycle in RUN, including stalls. It saturates at all-ones.
- Undefined: 0x110 reads 0 and no counter logic is built.

Test Plan:
- Reset with pushes pending: assert reset_n=0 mid-cycle -> outputs 0 immediately; after release, STATUS reads 0x008 (empty).
- Basic sum: push 5, 7, 0xFFFF_FFFF_FFFF_FFFF; COUNT=3; start -> busy 3 cycles, done=1, ACC=0x000...0B.
- Stall: COUNT=2; start with FIFO empty -> busy held, ACC=0. Push 10 then 20, spaced 4 cycles -> done after second pop, ACC=30.
- Overflow: push 9 values into depth-8 FIFO -> STATUS[2]=1, [4]=1, count=8. Clear -> ovf=0, ACC=0.
- Read latency/decode: read 0x108 -> mem_rdata = ACC on next cycle. Read 0x0F8 and 0x3F0 -> 0. Store to 0x040 -> no state change.
- Edge cases: COUNT=0 start -> done next cycle, ACC unchanged. Start while busy -> ignored. With ACC_CYCLE_CNT_EN, 0x110 equals RUN cycles (e.g. 3 for the basic sum).

Source files
------------

// File: rtl/mmio_acc_responder.sv
// MMIO responder: operand FIFO plus a sum-accumulate engine.
// Defining ACC_CYCLE_CNT_EN adds the RUN cycle counter at 0x110.
module mmio_acc_responder #(
   parameter int D_WIDTH    = 64,
   parameter int ADDR_WIDTH = 10,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] mem_addr_in,
   input  logic [D_WIDTH-1:0]    mem_data_in,
   input  logic                  mem_we,
   output logic [D_WIDTH-1:0]    mem_rdata,
   output logic                  busy,
   output logic                  done
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WA_W  = ADDR_WIDTH - 2;

   localparam logic [WA_W-1:0] A_CTRL   = WA_W'('h40);
   localparam logic [WA_W-1:0] A_STATUS = WA_W'('h41);
   localparam logic [WA_W-1:0] A_ACC    = WA_W'('h42);
   localparam logic [WA_W-1:0] A_COUNT  = WA_W'('h43);
   localparam logic [WA_W-1:0] A_CYCLES = WA_W'('h44);
   localparam logic [WA_W-1:0] A_FIFO   = WA_W'('h80);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]         r_state;
   logic [D_WIDTH-1:0] r_acc;
   logic [D_WIDTH-1:0] r_count;
   logic               r_ovf;
   logic [D_WIDTH-1:0] r_rdata;
   logic [D_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wptr;
   logic [PTR_W-1:0]   r_rptr;
   logic [CNT_W-1:0]   r_fcnt;

   logic [WA_W-1:0]    w_word;
   logic [1:0]         w_unused_addr;
   logic               w_wr_ctrl;
   logic               w_start;
   logic               w_start_ok;
   logic               w_clear;
   logic               w_wr_count;
   logic               w_push_req;
   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic [D_WIDTH-1:0] w_head;
   logic [D_WIDTH-1:0] w_status;
   logic [D_WIDTH-1:0] w_rdata;
   logic [D_WIDTH-1:0] w_cycles;

   assign w_word        = mem_addr_in[ADDR_WIDTH-1:2];
   assign w_unused_addr = mem_addr_in[1:0];

   // Clear dominates: a CTRL store with both bits set never starts the engine.
   assign w_wr_ctrl  = mem_we && (w_word == A_CTRL);
   assign w_clear    = w_wr_ctrl && mem_data_in[1];
   assign w_start    = w_wr_ctrl && mem_data_in[0] && !mem_data_in[1];
   assign w_start_ok = w_start && (r_state != S_RUN);
   assign w_wr_count = mem_we && (w_word == A_COUNT) && (r_state != S_RUN);
   assign w_push_req = mem_we && (w_word == A_FIFO);

   assign w_full  = (r_fcnt == CNT_W'(FIFO_DEPTH));
   assign w_empty = (r_fcnt == '0);
   assign w_head  = r_mem[r_rptr];
   assign w_pop   = (r_state == S_RUN) && !w_empty && (r_count != '0);
   assign w_push  = w_push_req && (!w_full || w_pop);

   assign busy      = (r_state == S_RUN);
   assign done      = (r_state == S_DONE);
   assign mem_rdata = r_rdata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (w_start) r_state <= S_RUN;
            S_RUN: begin
               if (r_count == '0)
                  r_state <= S_DONE;
               else if (w_pop && (r_count == D_WIDTH'(1)))
                  r_state <= S_DONE;
            end
            S_DONE: begin
               if (w_clear)      r_state <= S_IDLE;
               else if (w_start) r_state <= S_RUN;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc   <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_clear)    r_acc <= '0;
         else if (w_pop) r_acc <= r_acc + w_head;

         if (w_wr_count) r_count <= mem_data_in;
         else if (w_pop) r_count <= r_count - 1'b1;

         if (w_clear)                   r_ovf <= 1'b0;
         else if (w_push_req && !w_push) r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_fcnt <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_fcnt <= r_fcnt + 1'b1;
            2'b01:   r_fcnt <= r_fcnt - 1'b1;
            default: r_fcnt <= r_fcnt;
         endcase
      end
   end

   // Storage array needs no reset: occupancy is tracked by r_fcnt.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= mem_data_in;
   end

`ifdef ACC_CYCLE_CNT_EN
   logic [D_WIDTH-1:0] r_cycles;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_cycles <= '0;
      else if (w_clear || w_start_ok)
         r_cycles <= '0;
      else if ((r_state == S_RUN) && (r_cycles != '1))
         r_cycles <= r_cycles + 1'b1;
   end

   assign w_cycles = r_cycles;
`else
   assign w_cycles = '0;
`endif

   always_comb begin
      w_status       = '0;
      w_status[0]    = busy;
      w_status[1]    = done;
      w_status[2]    = w_full;
      w_status[3]    = w_empty;
      w_status[4]    = r_ovf;
      w_status[11:8] = 4'(r_fcnt);
   end

   always_comb begin
      w_rdata = '0;
      case (w_word)
         A_STATUS: w_rdata = w_status;
         A_ACC:    w_rdata = r_acc;
         A_COUNT:  w_rdata = r_count;
         A_CYCLES: w_rdata = w_cycles;
         A_FIFO:   w_rdata = D_WIDTH'(r_fcnt);
         default:  w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_rdata <= '0;
      else          r_rdata <= w_rdata;
   end

endmodule

// File: tb/tb_mmio_acc_responder.sv
// Scoreboard bench for mmio_acc_responder: expected read data is queued
// when a read is issued and compared once the registered data returns.
module tb_mmio_acc_responder;

   localparam logic [9:0] A_CTRL   = 10'h100;
   localparam logic [9:0] A_STATUS = 10'h104;
   localparam logic [9:0] A_ACC    = 10'h108;
   localparam logic [9:0] A_COUNT  = 10'h10C;
   localparam logic [9:0] A_CYCLES = 10'h110;
   localparam logic [9:0] A_FIFO   = 10'h200;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [9:0]  mem_addr_in;
   logic [63:0] mem_data_in;
   logic        mem_we;
   logic [63:0] mem_rdata;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_pass   = 0;

   logic [63:0] exp_q [$];
   logic [63:0] got_q [$];
   string       nm_q  [$];

   mmio_acc_responder #(.D_WIDTH(64), .ADDR_WIDTH(10), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .mem_addr_in(mem_addr_in),
      .mem_data_in(mem_data_in), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // All bus tasks start and end on a falling edge.
   task automatic wr(input logic [9:0] a, input logic [63:0] d);
      mem_addr_in = a; mem_data_in = d; mem_we = 1'b1;
      @(negedge clk);
      mem_we = 1'b0; mem_addr_in = '0; mem_data_in = '0;
   endtask

   task automatic rd(input logic [9:0] a, input logic [63:0] e, input string nm);
      exp_q.push_back(e); nm_q.push_back(nm);
      mem_addr_in = a; mem_we = 1'b0;
      @(posedge clk);
      #1 got_q.push_back(mem_rdata);
      @(negedge clk);
      mem_addr_in = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_done(input int max, output int nbusy);
      nbusy = 0;
      for (int i = 0; i < max; i++) begin
         if (done) break;
         if (busy) nbusy++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      logic [63:0] e, g; string n;
      wr(A_COUNT, 64'd5);
      wr(A_FIFO, 64'd1);
      wr(A_FIFO, 64'd2);
      wr(A_CTRL, 64'd1);
      mem_addr_in = A_STATUS;
      idle(4);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL reset_pre_busy: got %b expected 1", busy);
      else n_pass++;
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if (mem_rdata !== 64'd0) $display("FAIL reset_rdata: got %h expected 0", mem_rdata);
      else n_pass++;
      n_checks++;
      if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done: got %b expected 00", {busy, done});
      else n_pass++;
      @(negedge clk);
      reset_n = 1'b1;
      mem_addr_in = '0;
      rd(A_STATUS, 64'h008, "reset_status");
      rd(A_ACC, 64'd0, "reset_acc");
      rd(A_COUNT, 64'd0, "reset_count");
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
         n_checks++;
         if (g !== e) $display("FAIL %s: got %h expected %h", n, g, e);
         else n_pass++;
      end
   endtask

   task automatic test_basic_sum;
      logic [63:0] e, g; string n; int nb;
      wr(A_FIFO, 64'd5);
      wr(A_FIFO, 64'd7);
      wr(A_FIFO, 64'hFFFF_FFFF_FFFF_FFFF);
      wr(A_COUNT, 64'd3);
      wr(A_CTRL, 64'd1);
      wait_done(20, nb);
      n_checks++;
      if (nb != 3) $display("FAIL basic_busy_cycles: got %0d expected 3", nb);
      else n_pass++;
      n_checks++;
      if (done !== 1'b1) $display("FAIL basic_done: got %b expected 1", done);
      else n_pass++;
      rd(A_ACC, 64'h0B, "basic_acc");
      rd(A_STATUS, 64'h00A, "basic_status");
      rd(A_COUNT, 64'd0, "basic_count");
`ifdef ACC_CYCLE_CNT_EN
      rd(A_CYCLES, 64'd3, "basic_cycles");
`else
      rd(A_CYCLES, 64'd0, "basic_cycles");
`endif
      wr(A_CTRL, 64'd2);
      rd(A_ACC, 64'd0, "basic_clear_acc");
      rd(A_STATUS, 64'h008, "basic_clear_status");
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
         n_checks++;
         if (g !== e) $display("FAIL %s: got %h expected %h", n, g, e);
         else n_pass++;
      end
   endtask

   task automatic test_stall;
      logic [63:0] e, g; string n; int nb;
      wr(A_COUNT, 64'd2);
      wr(A_CTRL, 64'd1);
      idle(4);
      n_checks++;
      if ({busy, done} !== 2'b10) $display("FAIL stall_held: got %b expected 10", {busy, done});
      else n_pass++;
      rd(A_ACC, 64'd0, "stall_acc_empty");
      wr(A_FIFO, 64'd10);
      idle(3);
      rd(A_COUNT, 64'd1, "stall_count_mid");
      wr(A_FIFO, 64'd20);
      wait_done(10, nb);
      n_checks++;
      if (done !== 1'b1) $display("FAIL stall_done: got %b expected 1", done);
      else n_pass++;
      rd(A_ACC, 64'd30, "stall_acc");
      wr(A_CTRL, 64'd2);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
         n_checks++;
         if (g !== e) $display("FAIL %s: got %h expected %h", n, g, e);
         else n_pass++;
      end
   endtask

   task automatic test_overflow;
      logic [63:0] e, g; string n; int nb;
      for (int i = 1; i <= 9; i++) wr(A_FIFO, 64'(i));
      rd(A_STATUS, 64'h814, "ovf_status");
      rd(A_FIFO, 64'd8, "ovf_fifo_count");
      wr(A_CTRL, 64'd2);
      rd(A_STATUS, 64'h804, "ovf_clear_status");
      rd(A_ACC, 64'd0, "ovf_clear_acc");
      wr(A_COUNT, 64'd8);
      wr(A_CTRL, 64'd1);
      wait_done(30, nb);
      rd(A_ACC, 64'd36, "ovf_drain_acc");
      rd(A_STATUS, 64'h00A, "ovf_drain_status");
      wr(A_CTRL, 64'd2);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
         n_checks++;
         if (g !== e) $display("FAIL %s: got %h expected %h", n, g, e);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back;
      logic [63:0] e, g; string n; int nb;
      for (int i = 0; i < 8; i++) wr(A_FIFO, 64'd1);
      wr(A_COUNT, 64'd10);
      wr(A_CTRL, 64'd1);
      wr(A_FIFO, 64'd100);
      wr(A_CTRL, 64'd1);
      wr(A_COUNT, 64'd99);
      idle(10);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL b2b_busy: got %b expected 1", busy);
      else n_pass++;
      rd(A_COUNT, 64'd1, "b2b_count_mid");
      rd(A_STATUS, 64'h009, "b2b_status_mid");
      wr(A_FIFO, 64'd1000);
      wait_done(10, nb);
      rd(A_ACC, 64'd1108, "b2b_acc");
      rd(A_STATUS, 64'h00A, "b2b_status");
      rd(A_COUNT, 64'd0, "b2b_count");
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
         n_checks++;
         if (g !== e) $display("FAIL %s: got %h expected %h", n, g, e);
         else n_pass++;
      end
   endtask

   task automatic test_decode;
      logic [63:0] e, g; string n;
      rd(10'h0F8, 64'd0, "dec_low_window");
      rd(10'h3F0, 64'd0, "dec_unmapped");
      rd(A_CTRL, 64'd0, "dec_ctrl_read");
      rd(10'h10A, 64'd1108, "dec_acc_lowbits");
      wr(10'h040, 64'hFFFF_FFFF_FFFF_FFFF);
      wr(10'h30C, 64'd3);
      rd(A_ACC, 64'd1108, "dec_acc_after_stray");
      rd(A_STATUS, 64'h00A, "dec_status_after_stray");
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
         n_checks++;
         if (g !== e) $display("FAIL %s: got %h expected %h", n, g, e);
         else n_pass++;
      end
   endtask

   task automatic test_restart;
      logic [63:0] e, g; string n; int nb;
      wr(A_COUNT, 64'd1);
      wr(A_FIFO, 64'd5);
      wr(A_CTRL, 64'd1);
      wait_done(10, nb);
      rd(A_ACC, 64'd1113, "restart_acc");
      wr(A_CTRL, 64'd1);
      n_checks++;
      if ({busy, done} !== 2'b10) $display("FAIL zero_count_run: got %b expected 10", {busy, done});
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({busy, done} !== 2'b01) $display("FAIL zero_count_done: got %b expected 01", {busy, done});
      else n_pass++;
      rd(A_ACC, 64'd1113, "zero_count_acc");
`ifdef ACC_CYCLE_CNT_EN
      rd(A_CYCLES, 64'd1, "zero_count_cycles");
`else
      rd(A_CYCLES, 64'd0, "zero_count_cycles");
`endif
      wr(A_CTRL, 64'd3);
      rd(A_STATUS, 64'h008, "clear_wins_status");
      rd(A_ACC, 64'd0, "clear_wins_acc");
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
         n_checks++;
         if (g !== e) $display("FAIL %s: got %h expected %h", n, g, e);
         else n_pass++;
      end
   endtask

   initial begin
      reset_n = 1'b0; mem_addr_in = '0; mem_data_in = '0; mem_we = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      test_reset();
      test_basic_sum();
      test_stall();
      test_overflow();
      test_back_to_back();
      test_decode();
      test_restart();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
